// File: rtl/mem_if_pkg.sv
// Shared definitions for the mem_master CPU-to-memory bridge.
//   - FSM state encoding (ISSUE2/CAPTURE2 exist only with MEM_MASTER_UNALIGNED_EN)
//   - MEM_BYTES default and request latency constants (cycles from accept to resp_valid)
//   - access_err(): range / alignment check applied to an incoming request
// Optional feature macro: MEM_MASTER_UNALIGNED_EN (split odd-address word accesses).
package mem_if_pkg;

   localparam int MEM_BYTES_DEFAULT = 128;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ISSUE    = 3'd1;
   localparam logic [2:0] ST_CAPTURE  = 3'd2;
   localparam logic [2:0] ST_RESP     = 3'd3;
`ifdef MEM_MASTER_UNALIGNED_EN
   localparam logic [2:0] ST_ISSUE2   = 3'd4;
   localparam logic [2:0] ST_CAPTURE2 = 3'd5;
`endif

   localparam int LAT_ERR         = 1;
   localparam int LAT_LOAD        = 3;
   localparam int LAT_STORE       = 2;
   localparam int LAT_SPLIT_LOAD  = 5;
   localparam int LAT_SPLIT_STORE = 3;

   // The second byte of an unaligned word uses addr+1 computed in 16 bits,
   // so 0xFFFF wraps to 0x0000 before being range-checked.
   function automatic logic access_err(input logic [15:0] addr,
                                       input logic        byte_acc,
                                       input logic [31:0] limit);
`ifdef MEM_MASTER_UNALIGNED_EN
      logic [15:0] addr_p1;
      addr_p1 = addr + 16'd1;
`endif
      access_err = ({16'h0000, addr} >= limit);
      if (!byte_acc && addr[0]) begin
`ifdef MEM_MASTER_UNALIGNED_EN
         if ({16'h0000, addr_p1} >= limit) access_err = 1'b1;
`else
         access_err = 1'b1;
`endif
      end
   endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering between CPU data and the memory bus.
//   st_byte/st_hi/st_wdata -> st_lane : store data (byte stores put the chosen
//                                       byte in [7:0], upper lane zero)
//   ld_byte/ld_merge/ld_lo/mem_rdata -> ld_data : load result (memory already
//                                       lane-shifts bytes into [7:0])
module mem_lane_steer (
   input  logic        st_byte,
   input  logic        st_hi,
   input  logic [15:0] st_wdata,
   output logic [15:0] st_lane,
   input  logic        ld_byte,
   input  logic        ld_merge,
   input  logic [7:0]  ld_lo,
   input  logic [15:0] mem_rdata,
   output logic [15:0] ld_data
);

   always_comb begin
      st_lane = st_wdata;
      if (st_byte) st_lane = {8'h00, (st_hi ? st_wdata[15:8] : st_wdata[7:0])};

      ld_data = mem_rdata;
      // merge: second byte of a split load becomes the upper byte
      if (ld_merge)     ld_data = {mem_rdata[7:0], ld_lo};
      else if (ld_byte) ld_data = {8'h00, mem_rdata[7:0]};
   end

endmodule

// File: rtl/mem_master.sv
// CPU request -> single-port memory bus master.
//   req_*  : CPU request (valid/ready handshake, write, byte, addr, wdata)
//   resp_* : one-cycle completion pulse with load data and error flag
//   mem_*  : registered memory bus (word address, byte select/enable, wait)
// Synchronous active-high rst. Optional macro MEM_MASTER_UNALIGNED_EN splits
// odd-address word accesses into two byte accesses; without it they error.
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// ISSUE    | mem_en high, held while mem_wait
// CAPTURE  | load data sampled from mem_rdata
// ISSUE2   | second byte of a split access (unaligned build only)
// CAPTURE2 | second byte of a split load captured (unaligned build only)
// RESP     | resp_valid pulse
module mem_master
   import mem_if_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_byte,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_en,
   output logic        mem_write_enable,
   output logic        mem_byte_select,
   output logic        mem_byte_enable,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_wait
);

   logic [2:0]  state;
   logic        q_write;
   logic        q_byte;
   logic        acc_err;
   logic        split_req;
   logic        st_byte;
   logic        st_hi;
   logic        ld_merge;
   logic [7:0]  ld_lo;
   logic [15:0] st_wdata;
   logic [15:0] st_lane;
   logic [15:0] ld_data;

   assign req_ready = (state == ST_IDLE);
   assign acc_err   = access_err(req_addr, req_byte, 32'(MEM_BYTES));

`ifdef MEM_MASTER_UNALIGNED_EN
   logic        q_split;
   logic [15:0] q_addr_p1;
   logic [15:0] q_wdata;
   logic [7:0]  lo_q;

   assign split_req = !req_byte && req_addr[0];
   // In IDLE the steer sees the live request; afterwards only the second
   // byte of a split store uses it, always the upper byte of latched data.
   assign st_byte   = (state == ST_IDLE) ? (req_byte || split_req) : 1'b1;
   assign st_hi     = (state != ST_IDLE);
   assign st_wdata  = (state == ST_IDLE) ? req_wdata : q_wdata;
   assign ld_merge  = (state == ST_CAPTURE2);
   assign ld_lo     = lo_q;
`else
   assign split_req = 1'b0;
   assign st_byte   = req_byte;
   assign st_hi     = 1'b0;
   assign st_wdata  = req_wdata;
   assign ld_merge  = 1'b0;
   assign ld_lo     = 8'h00;
`endif

   mem_lane_steer u_steer (
      .st_byte   (st_byte),
      .st_hi     (st_hi),
      .st_wdata  (st_wdata),
      .st_lane   (st_lane),
      .ld_byte   (q_byte),
      .ld_merge  (ld_merge),
      .ld_lo     (ld_lo),
      .mem_rdata (mem_rdata),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         q_write          <= 1'b0;
         q_byte           <= 1'b0;
         resp_valid       <= 1'b0;
         resp_err         <= 1'b0;
         resp_rdata       <= 16'h0000;
         mem_en           <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_byte_select  <= 1'b0;
         mem_byte_enable  <= 1'b0;
         mem_addr         <= 16'h0000;
         mem_wdata        <= 16'h0000;
`ifdef MEM_MASTER_UNALIGNED_EN
         q_split          <= 1'b0;
         q_addr_p1        <= 16'h0000;
         q_wdata          <= 16'h0000;
         lo_q             <= 8'h00;
`endif
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 16'h0000;

         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  q_write <= req_write;
                  q_byte  <= req_byte;
`ifdef MEM_MASTER_UNALIGNED_EN
                  q_split   <= split_req;
                  q_addr_p1 <= req_addr + 16'd1;
                  q_wdata   <= req_wdata;
`endif
                  if (acc_err) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state            <= ST_ISSUE;
                     mem_en           <= 1'b1;
                     mem_write_enable <= req_write;
                     mem_byte_select  <= req_addr[0];
                     mem_byte_enable  <= req_byte || split_req;
                     mem_addr         <= {1'b0, req_addr[15:1]};
                     mem_wdata        <= req_write ? st_lane : 16'h0000;
                  end
               end
            end

            ST_ISSUE: begin
               if (!mem_wait) begin
`ifdef MEM_MASTER_UNALIGNED_EN
                  // split store: keep mem_en high and move straight to byte 2
                  if (q_split && q_write) begin
                     state           <= ST_ISSUE2;
                     mem_byte_select <= q_addr_p1[0];
                     mem_addr        <= {1'b0, q_addr_p1[15:1]};
                     mem_wdata       <= st_lane;
                  end else
`endif
                  if (q_write) begin
                     state            <= ST_RESP;
                     resp_valid       <= 1'b1;
                     mem_en           <= 1'b0;
                     mem_write_enable <= 1'b0;
                  end else begin
                     state  <= ST_CAPTURE;
                     mem_en <= 1'b0;
                  end
               end
            end

            ST_CAPTURE: begin
`ifdef MEM_MASTER_UNALIGNED_EN
               if (q_split) begin
                  lo_q            <= mem_rdata[7:0];
                  state           <= ST_ISSUE2;
                  mem_en          <= 1'b1;
                  mem_byte_select <= q_addr_p1[0];
                  mem_addr        <= {1'b0, q_addr_p1[15:1]};
               end else
`endif
               begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= ld_data;
               end
            end

`ifdef MEM_MASTER_UNALIGNED_EN
            ST_ISSUE2: begin
               if (!mem_wait) begin
                  mem_en           <= 1'b0;
                  mem_write_enable <= 1'b0;
                  if (q_write) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                  end else begin
                     state <= ST_CAPTURE2;
                  end
               end
            end

            ST_CAPTURE2: begin
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_rdata <= ld_data;
            end
`endif

            ST_RESP: state <= ST_IDLE;

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

   localparam int MB = 128;
`ifdef MEM_MASTER_UNALIGNED_EN
   localparam bit UNAL = 1'b1;
`else
   localparam bit UNAL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_byte;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [15:0] resp_rdata;
   logic        mem_en, mem_write_enable, mem_byte_select, mem_byte_enable;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_wait;

   always #5 clk = ~clk;

   mem_master #(.MEM_BYTES(MB)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_en(mem_en), .mem_write_enable(mem_write_enable),
      .mem_byte_select(mem_byte_select), .mem_byte_enable(mem_byte_enable),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_wait(mem_wait)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  phys    [256];  // contents of the memory the DUT talks to
   logic [7:0]  ref_mem [256];  // reference model's view of the same bytes
   int          wait_n = 0;
   logic [34:0] acc_log [$];    // {we, be, sel, word addr, wdata} per completed access
   int          stab_err = 0;

   // memory-side responder state
   bit          cap_pending = 1'b0;
   bit          active = 1'b0;
   logic [15:0] pend = 16'h0;
   int          waited = 0;
   logic [34:0] snap, cur;
   logic [7:0]  bidx, widx;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory: completes an access on the first edge with mem_en && !mem_wait,
   // returns load data only in the following cycle, garbage otherwise.
   initial begin : mem_side
      mem_wait  = 1'b0;
      mem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         mem_rdata   = cap_pending ? pend : 16'($urandom);
         cap_pending = 1'b0;
         cur = {mem_write_enable, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata};
         if (mem_en === 1'b1 && rst === 1'b0) begin
            if (!active) begin
               active = 1'b1;
               snap   = cur;
            end else if (cur !== snap) begin
               stab_err++;
            end
            if (waited < wait_n) begin
               mem_wait = 1'b1;
               waited++;
            end else begin
               mem_wait = 1'b0;
               waited   = 0;
               active   = 1'b0;
               bidx = {mem_addr[6:0], mem_byte_select};
               widx = {mem_addr[6:0], 1'b0};
               if (mem_write_enable) begin
                  if (mem_byte_enable) phys[bidx] = mem_wdata[7:0];
                  else begin
                     phys[widx]      = mem_wdata[7:0];
                     phys[widx + 1]  = mem_wdata[15:8];
                  end
               end else begin
                  pend = mem_byte_enable ? {8'h00, phys[bidx]} : {phys[widx + 1], phys[widx]};
                  cap_pending = 1'b1;
               end
               acc_log.push_back({mem_write_enable, mem_byte_enable, mem_byte_select, mem_addr,
                                  (mem_write_enable ? mem_wdata : 16'h0000)});
            end
         end else begin
            mem_wait = 1'($urandom_range(0, 1));
            waited   = 0;
            active   = 1'b0;
         end
      end
   end

   task automatic poke(input logic [15:0] a, input logic [7:0] v);
      phys[a[7:0]]    = v;
      ref_mem[a[7:0]] = v;
   endtask

   task automatic do_req(input string tag, input bit wr, input bit by,
                         input logic [15:0] addr, input logic [15:0] wd, input int w);
      bit          err, split, ready_ok;
      int          exp_lat, got_lat, en_cnt;
      logic [15:0] a1, exp_rd;
      logic [34:0] exp_acc [$];

      a1      = addr + 16'd1;
      err     = (int'(addr) >= MB) || (!by && addr[0] && (!UNAL || int'(a1) >= MB));
      split   = !by && addr[0] && !err;
      exp_lat = err ? 1 : split ? (wr ? 3 + 2*w : 5 + 2*w) : (wr ? 2 + w : 3 + w);
      exp_rd  = 16'h0000;
      if (!err && !wr) exp_rd = by ? {8'h00, ref_mem[addr[7:0]]} : {ref_mem[a1[7:0]], ref_mem[addr[7:0]]};
      if (!err && wr) begin
         ref_mem[addr[7:0]] = wd[7:0];
         if (!by) ref_mem[a1[7:0]] = wd[15:8];
      end
      if (!err) begin
         if (split) begin
            exp_acc.push_back({wr, 1'b1, addr[0], addr >> 1, (wr ? {8'h00, wd[7:0]}  : 16'h0)});
            exp_acc.push_back({wr, 1'b1, a1[0],   a1 >> 1,   (wr ? {8'h00, wd[15:8]} : 16'h0)});
         end else begin
            exp_acc.push_back({wr, by, addr[0], addr >> 1,
                               (wr ? (by ? {8'h00, wd[7:0]} : wd) : 16'h0)});
         end
      end

      wait_n   = w;
      stab_err = 0;
      acc_log.delete();
      req_valid = 1'b1; req_write = wr; req_byte = by; req_addr = addr; req_wdata = wd;
      check({tag, ":ready_before"}, req_ready, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = 1'($urandom); req_byte = 1'($urandom);
      req_addr  = 16'($urandom); req_wdata = 16'($urandom);

      got_lat = 0; en_cnt = 0; ready_ok = 1'b1;
      for (int k = 1; k <= 40 && got_lat == 0; k++) begin
         @(negedge clk);
         if (mem_en === 1'b1) en_cnt++;
         if (req_ready !== 1'b0) ready_ok = 1'b0;
         if (resp_valid === 1'b1) begin
            got_lat = k;
            check({tag, ":rdata"}, resp_rdata, exp_rd);
            check({tag, ":err"}, resp_err, err);
         end
      end
      check({tag, ":latency"}, got_lat, exp_lat);
      check({tag, ":mem_en_cycles"}, en_cnt, err ? 0 : (split ? 2 : 1) * (1 + w));
      check({tag, ":busy_not_ready"}, ready_ok, 1'b1);
      check({tag, ":bus_stable"}, stab_err, 0);
      check({tag, ":n_access"}, acc_log.size(), exp_acc.size());
      for (int i = 0; i < exp_acc.size() && i < acc_log.size(); i++)
         check({tag, ":access"}, acc_log[i], exp_acc[i]);
      @(negedge clk);
      check({tag, ":pulse_one_cycle"}, resp_valid, 1'b0);
      check({tag, ":ready_after"}, req_ready, 1'b1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
      req_addr = 16'h0; req_wdata = 16'h0;
      for (int i = 0; i < 256; i++) begin
         phys[i]    = 8'($urandom);
         ref_mem[i] = phys[i];
      end
      repeat (3) @(negedge clk);
      check("rst:req_ready", req_ready, 1'b1);
      check("rst:resp", {resp_valid, resp_err, resp_rdata}, 18'h0);
      check("rst:mem_ctl", {mem_en, mem_write_enable, mem_byte_select, mem_byte_enable}, 4'h0);
      check("rst:mem_addr", mem_addr, 16'h0);
      check("rst:mem_wdata", mem_wdata, 16'h0);
      rst = 1'b0;
      @(negedge clk);

      poke(16'h0004, 8'hEF); poke(16'h0005, 8'hBE);
      do_req("wload_0004", 1'b0, 1'b0, 16'h0004, 16'h0, 0);
      do_req("bstore_0007", 1'b1, 1'b1, 16'h0007, 16'h12AB, 0);
      do_req("bload_0007", 1'b0, 1'b1, 16'h0007, 16'h0, 0);
      do_req("wload_wait3", 1'b0, 1'b0, 16'h0020, 16'h0, 3);
      do_req("wstore_wait2", 1'b1, 1'b0, 16'h0030, 16'hC0DE, 2);
      do_req("load_0080", 1'b0, 1'b0, 16'h0080, 16'h0, 0);
      do_req("bstore_0080", 1'b1, 1'b1, 16'h0080, 16'h5555, 0);
      do_req("wload_007F", 1'b0, 1'b0, 16'h007F, 16'h0, 0);
      do_req("bload_007F", 1'b0, 1'b1, 16'h007F, 16'h0, 0);
      do_req("wstore_007E", 1'b1, 1'b0, 16'h007E, 16'hA55A, 0);
      do_req("wload_FFFF", 1'b0, 1'b0, 16'hFFFF, 16'h0, 0);
      poke(16'h0003, 8'h34); poke(16'h0004, 8'h12);
      do_req("wload_0003", 1'b0, 1'b0, 16'h0003, 16'h0, 0);
      do_req("wstore_0005", 1'b1, 1'b0, 16'h0005, 16'h9876, 1);
      do_req("bload_0005", 1'b0, 1'b1, 16'h0005, 16'h0, 0);
      do_req("bload_0006", 1'b0, 1'b1, 16'h0006, 16'h0, 0);

      // reset while the load sits in CAPTURE
      wait_n = 0;
      req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0010;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid:resp_valid", resp_valid, 1'b0);
      check("rst_mid:req_ready", req_ready, 1'b1);
      check("rst_mid:mem_en", mem_en, 1'b0);
      @(negedge clk);
      check("rst_mid:no_late_resp", resp_valid, 1'b0);
      do_req("after_rst", 1'b0, 1'b0, 16'h0010, 16'h0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] ra;
         ra = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                          : 16'($urandom_range(0, 135));
         do_req("rand", 1'($urandom), 1'($urandom), ra, 16'($urandom), int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
